ctrl_pipe_cond: RTL
===================

Name: ctrl_pipe_cond

Overview:
- Parametrised control-signal pipeline between the instruction decoder and the later pipeline stages.
- Carries decoded control fields through NSTAGE registered stages: stage 0 = Execute, then Memory, Writeback, and any extra stages.
- At stage 0 it evaluates the ARM condition code against an internal NZCV flag register, gates the write enables, updates the flags, and applies the multicycle-result override.
- Each stage has its own stall and flush. Bubbles are inserted automatically when an upstream stage holds.

Parameters:
- NSTAGE, 3, number of pipeline stages after decode (legal range 2..8).
- CTRL_W, 8, width of the pass-through control bundle (MemtoReg, ALUSrc, ALUControl, ...).
- MEMTOREG_IDX, 0, bit of the control bundle cleared by the multicycle override.

Ports:
- CLK  in  1  clock.
- Reset_n  in  1  asynchronous active-low reset.
- Valid_D  in  1  decode-stage instruction valid; 0 makes stage 0 load a bubble.
- RegW_D  in  1  decoded register write.
- MemW_D  in  1  decoded memory write.
- PCS_D  in  1  decoded PC write.
- NoWrite_D  in  1  compare-type instruction; suppresses the register write.
- FlagW_D  in  2  flag write: [1] updates NZ, [0] updates CV.
- Cond_D  in  4  condition field.
- Ctrl_D  in  CTRL_W  pass-through control bundle.
- ALUFlags  in  4  NZCV produced by the ALU for the stage-0 instruction.
- MC_done  in  1  multicycle unit is returning its result through stage 0.
- Stall  in  NSTAGE  per-stage hold.
- Flush  in  NSTAGE  per-stage clear.
- PCSrc_E  out  1  gated PC write at stage 0 (combinational).
- RegWrite_S  out  NSTAGE  gated register write per stage; bit 0 combinational, bits k≥1 registered.
- MemWrite_S  out  NSTAGE  gated memory write per stage; same timing as RegWrite_S.
- Valid_S  out  NSTAGE  stage valid.
- Ctrl_S  out  NSTAGE*CTRL_W  control bundle per stage; stage k occupies bits [k*CTRL_W +: CTRL_W].
- Flags  out  4  current NZCV register.
- CondEx_E  out  1  condition result for stage 0.

Behaviour:
- Reset: all stage registers (valid, RegW, MemW, PCS, NoWrite, FlagW, Cond, Ctrl) and Flags go to 0 asynchronously. All outputs read 0, except CondEx_E, which reflects Cond=0 (EQ) against Z=0, i.e. 0.
- Stage 0 raw fields are registered. CondEx_E decodes from Flags using ARM semantics:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL=1; 4'b1111 is treated as always.
- Stage 0 gating:
  - PCSrc_E = V0&PCS0&CondEx_E.
  - RegWrite_S[0] = V0&RegW0&CondEx_E&!NoWrite0.
  - MemWrite_S[0] = V0&MemW0&CondEx_E.
- MC_done=1 overrides gating: RegWrite_S[0]=1, MemWrite_S[0]=0, PCSrc_E=0, and the Ctrl bit MEMTOREG_IDX as seen by stage 1 is forced to 0.
- Flag update on a clock edge when V0 & CondEx_E & !Stall[0] & !MC_done & !Flush[0]:
  - NZ <= ALUFlags[3:2] if FlagW0[1].
  - CV <= ALUFlags[1:0] if FlagW0[0].
  - The next instruction entering stage 0 sees the updated flags.
- Stage 0 load priority: Flush[0] -> bubble (all 0); else Stall[0] -> hold; else load the _D inputs with valid=Valid_D.
- Stage k≥1 load priority: Flush[k] -> bubble; else Stall[k] -> hold; else Stall[k-1] -> bubble (prevents duplication); else load the gated stage k-1 values.
- Only gated enables and Ctrl propagate beyond stage 0. Bubble stages drive 0 on all enables.
- Flush and Stall asserted together on one stage: flush wins.
- Latency: decode to stage k output is k+1 edges with no stalls.
- Reset asserted mid-stall or mid-multicycle clears everything, including pending flags.

Optional Feature:
- Macro CTRL_SQUASH_CNT_EN. When defined:
  - Adds output SquashCnt (16 bits), reset 0.
  - Increments on each edge where V0 & !CondEx_E & !Stall[0] & !Flush[0] & !MC_done.
  - Saturates at 16'hFFFF.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, no stalls, Valid_D=1, RegW_D=1, Cond=AL, Ctrl_D=8'hA5 -> RegWrite_S=3'b001, then 3'b011, then 3'b111 on successive edges; Ctrl_S stage 2 = 8'hA5 after 3 edges.
- CMP-type instruction (NoWrite=1, FlagW=2'b11, ALUFlags=4'b0100) followed by MOVEQ (RegW=1, Cond=0000) -> Flags=4'b0100, MOVEQ RegWrite_S[0]=1; same sequence with Cond=NE -> RegWrite_S[0]=0, MemWrite_S[0]=0.
- Stall[0]=1 for 2 cycles, Stall[1]=0 -> stage 0 holds its instruction, stage 1 receives 2 bubbles (Valid_S[1]=0), then the instruction advances once; no duplicate.
- Flush[0]=1 together with Stall[0]=1 on a branch instruction -> stage 0 becomes bubble next edge, PCSrc_E=0, Flags unchanged.
- MC_done=1 with stage-0 instruction MemW=1, Ctrl[0]=1 -> RegWrite_S[0]=1, MemWrite_S[0]=0, stage-1 Ctrl[0]=0, Flags unchanged despite FlagW=2'b11.
- CTRL_SQUASH_CNT_EN defined: 3 condition-failed instructions plus 1 stalled failed instruction (held 2 cycles, then advanced) -> SquashCnt=4; Reset_n low mid-run -> 0 immediately.

Source files
------------

// File: rtl/ctrl_pipe_cond_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_cond_if
// Purpose  : Bundle between the decoder / hazard unit and ctrl_pipe_cond.
//            The master drives the decoded fields, ALU flags, multicycle
//            status and per-stage stall/flush. The slave returns the gated
//            enables, per-stage control, and the condition and flag state.
//            The SquashCnt member exists only when CTRL_SQUASH_CNT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_pipe_cond_if #(
    parameter int NSTAGE = 3,
    parameter int CTRL_W = 8
);
    logic                     Valid_D;
    logic                     RegW_D;
    logic                     MemW_D;
    logic                     PCS_D;
    logic                     NoWrite_D;
    logic [1:0]               FlagW_D;
    logic [3:0]               Cond_D;
    logic [CTRL_W-1:0]        Ctrl_D;
    logic [3:0]               ALUFlags;
    logic                     MC_done;
    logic [NSTAGE-1:0]        Stall;
    logic [NSTAGE-1:0]        Flush;

    logic                     PCSrc_E;
    logic [NSTAGE-1:0]        RegWrite_S;
    logic [NSTAGE-1:0]        MemWrite_S;
    logic [NSTAGE-1:0]        Valid_S;
    logic [NSTAGE*CTRL_W-1:0] Ctrl_S;
    logic [3:0]               Flags;
    logic                     CondEx_E;
`ifdef CTRL_SQUASH_CNT_EN
    logic [15:0]              SquashCnt;
`endif

    modport master (
        output Valid_D, RegW_D, MemW_D, PCS_D, NoWrite_D, FlagW_D, Cond_D,
               Ctrl_D, ALUFlags, MC_done, Stall, Flush,
        input  PCSrc_E, RegWrite_S, MemWrite_S, Valid_S, Ctrl_S, Flags,
               CondEx_E
`ifdef CTRL_SQUASH_CNT_EN
        , input SquashCnt
`endif
    );

    modport slave (
        input  Valid_D, RegW_D, MemW_D, PCS_D, NoWrite_D, FlagW_D, Cond_D,
               Ctrl_D, ALUFlags, MC_done, Stall, Flush,
        output PCSrc_E, RegWrite_S, MemWrite_S, Valid_S, Ctrl_S, Flags,
               CondEx_E
`ifdef CTRL_SQUASH_CNT_EN
        , output SquashCnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe_cond.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_cond
// Purpose  : Control pipeline from decode through NSTAGE stages. Stage 0
//            (Execute) evaluates the ARM condition code against the NZCV
//            register, gates the write enables, updates the flags, and
//            applies the multicycle-result override. Each stage has its own
//            stall and flush. A bubble follows a stage that is held.
// Options  : CTRL_SQUASH_CNT_EN - adds a saturating 16-bit count of
//            condition-failed instructions that retire from stage 0.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe_cond #(
    parameter int NSTAGE       = 3,
    parameter int CTRL_W       = 8,
    parameter int MEMTOREG_IDX = 0
) (
    input  logic             CLK,
    input  logic             Reset_n,
    ctrl_pipe_cond_if.slave  bus
);
    // Per-stage state. Index 0 holds the raw decoded enables.
    // Index k>=1 holds the enables already gated at stage 0.
    logic [NSTAGE-1:0] vld_q;
    logic [NSTAGE-1:0] rw_q;
    logic [NSTAGE-1:0] mw_q;
    logic [CTRL_W-1:0] ctrl_q [NSTAGE];

    // Fields used only at stage 0
    logic              pcs0;
    logic              nowrite0;
    logic [1:0]        flagw0;
    logic [3:0]        cond0;
    logic [3:0]        flags_q;

    logic              cond_ex;
    logic              pcsrc_g0;
    logic              rw_g0;
    logic              mw_g0;
    logic [CTRL_W-1:0] ctrl_fwd0;
    logic              flag_upd;

    // ARM condition decode against the current NZCV value
    always_comb begin
        cond_ex = 1'b1;
        case (cond0)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            default: cond_ex = 1'b1;   // AL, and 4'b1111 treated as always
        endcase
    end

    // Stage-0 enable gating. A returning multicycle result takes the slot:
    // it forces the register write and blocks memory, PC and MemtoReg.
    always_comb begin
        pcsrc_g0  = vld_q[0] & pcs0 & cond_ex;
        rw_g0     = vld_q[0] & rw_q[0] & cond_ex & ~nowrite0;
        mw_g0     = vld_q[0] & mw_q[0] & cond_ex;
        ctrl_fwd0 = ctrl_q[0];
        if (bus.MC_done) begin
            pcsrc_g0                = 1'b0;
            rw_g0                   = 1'b1;
            mw_g0                   = 1'b0;
            ctrl_fwd0[MEMTOREG_IDX] = 1'b0;
        end
    end

    // Flags change only when the stage-0 instruction passes its condition
    // and actually leaves stage 0 (no stall, no flush, no multicycle result).
    assign flag_upd = vld_q[0] & cond_ex & ~bus.Stall[0] & ~bus.MC_done & ~bus.Flush[0];

    // Pipeline registers: stage-0 load from decode, then stages 1..NSTAGE-1
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_q    <= '0;
            rw_q     <= '0;
            mw_q     <= '0;
            pcs0     <= 1'b0;
            nowrite0 <= 1'b0;
            flagw0   <= 2'b00;
            cond0    <= 4'b0000;
            for (int k = 0; k < NSTAGE; k++) begin
                ctrl_q[k] <= '0;
            end
        end else begin
            if (bus.Flush[0]) begin
                vld_q[0]  <= 1'b0;
                rw_q[0]   <= 1'b0;
                mw_q[0]   <= 1'b0;
                pcs0      <= 1'b0;
                nowrite0  <= 1'b0;
                flagw0    <= 2'b00;
                cond0     <= 4'b0000;
                ctrl_q[0] <= '0;
            end else if (!bus.Stall[0]) begin
                vld_q[0]  <= bus.Valid_D;
                rw_q[0]   <= bus.RegW_D;
                mw_q[0]   <= bus.MemW_D;
                pcs0      <= bus.PCS_D;
                nowrite0  <= bus.NoWrite_D;
                flagw0    <= bus.FlagW_D;
                cond0     <= bus.Cond_D;
                ctrl_q[0] <= bus.Ctrl_D;
            end

            for (int k = 1; k < NSTAGE; k++) begin
                // A bubble goes in when the upstream stage holds, so the held
                // instruction is not duplicated downstream.
                if (bus.Flush[k] || (!bus.Stall[k] && bus.Stall[k-1])) begin
                    vld_q[k]  <= 1'b0;
                    rw_q[k]   <= 1'b0;
                    mw_q[k]   <= 1'b0;
                    ctrl_q[k] <= '0;
                end else if (!bus.Stall[k]) begin
                    if (k == 1) begin
                        vld_q[k]  <= vld_q[0];
                        rw_q[k]   <= rw_g0;
                        mw_q[k]   <= mw_g0;
                        ctrl_q[k] <= ctrl_fwd0;
                    end else begin
                        vld_q[k]  <= vld_q[k-1];
                        rw_q[k]   <= rw_q[k-1];
                        mw_q[k]   <= mw_q[k-1];
                        ctrl_q[k] <= ctrl_q[k-1];
                    end
                end
            end
        end
    end

    // NZCV register with separate NZ and CV write enables
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            flags_q <= 4'b0000;
        end else if (flag_upd) begin
            if (flagw0[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (flagw0[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
        end
    end

`ifdef CTRL_SQUASH_CNT_EN
    logic [15:0] squash_q;

    // Count condition-failed instructions as they leave stage 0; saturates
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            squash_q <= 16'h0000;
        end else if (vld_q[0] && !cond_ex && !bus.Stall[0] && !bus.Flush[0]
                     && !bus.MC_done && (squash_q != 16'hFFFF)) begin
            squash_q <= squash_q + 16'h0001;
        end
    end

    assign bus.SquashCnt = squash_q;
`endif

    // Output packing. Stage 0 enables are the gated combinational values.
    always_comb begin
        bus.Ctrl_S = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            bus.Ctrl_S[k*CTRL_W +: CTRL_W] = ctrl_q[k];
        end
    end

    assign bus.PCSrc_E    = pcsrc_g0;
    assign bus.RegWrite_S = {rw_q[NSTAGE-1:1], rw_g0};
    assign bus.MemWrite_S = {mw_q[NSTAGE-1:1], mw_g0};
    assign bus.Valid_S    = vld_q;
    assign bus.Flags      = flags_q;
    assign bus.CondEx_E   = cond_ex;

endmodule
`default_nettype wire
